control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Multi-cycle control stage directly upstream of read_registers.
//  - Accepts one 32-bit MIPS instruction per valid/ready handshake and decodes rs/rt/rd/opcode/funct.
//  - Sequences the register-file read, waits for the ALU, then drives RegWrite/RegDst/write_data for writeback.
//  - Processes one instruction at a time; no pipelining.
// PARAMETERS
//  EXEC_TIMEOUT  15  max cycles in EXEC waiting for alu_done before abort (1..255)
// PORTS
//  clk          in   1   single clock; all state updates on posedge
//  reset        in   1   synchronous, active-high
//  instr        in   32  instruction word
//  instr_valid  in   1   instr is valid this cycle
//  instr_ready  out  1   sequencer can accept instr (== state IDLE)
//  alu_result   in   32  ALU result, sampled on alu_done
//  alu_done     in   1   one-cycle ALU completion strobe
//  alu_start    out  1   one-cycle pulse: operands valid, start ALU
//  rs, rt, rd   out  5   instr[25:21], [20:16], [15:11] of held instruction
//  opcode       out  6   instr[31:26];  funct out 6 = instr[5:0]
//  RegRead      out  1   register-file read enable
//  RegWrite     out  1   register-file write enable
//  RegDst       out  1   1 = write rd, 0 = write rt
//  write_data   out  32  writeback data
//  busy         out  1   state != IDLE
//  error        out  1   one-cycle pulse: unsupported opcode or EXEC timeout
// BEHAVIOUR
//  Reset (sync): state=IDLE; every output 0 except instr_ready=1 from the first cycle after reset deasserts.
//  Reset mid-operation: abort on the next edge; no RegWrite; write_data cleared to 0.
//  Instruction register:
//  - Loaded only on the handshake (instr_valid & instr_ready).
//  - rs/rt/rd/opcode/funct are registered from it and stay stable until the next handshake.
//  Decode classes:
//  - opcode 0x00, funct!=0x08: R-type; reads rs,rt; writes rd; RegDst=1.
//  - opcode 0x00, funct==0x08 (JR): reads rs; no write.
//  - opcode 0x08-0x0F, 0x23, 0x24, 0x25: I-type; writes rt; RegDst=0.
//  - anything else: unsupported.
//  FSM:
//  - IDLE: instr_ready=1; on handshake -> DECODE.
//  - DECODE: fields valid. Unsupported -> IDLE with error=1 for one cycle. Otherwise -> READ.
//  - READ: RegRead=1 for exactly this cycle -> EXEC; alu_start=1 in the first EXEC cycle only.
//  - EXEC: 8-bit wait counter cleared on entry, increments each cycle.
//    - alu_done=1: capture alu_result into hold reg; -> WB_SETUP if the instruction writes, else -> IDLE.
//    - counter==EXEC_TIMEOUT with no alu_done: error pulse, -> IDLE, no write.
//    - alu_done in the same cycle as timeout: alu_done wins.
//  - WB_SETUP: RegWrite=1, RegDst valid; write_data unchanged -> WB_COMMIT.
//  - WB_COMMIT: RegWrite=1, RegDst held; write_data <= hold reg -> IDLE.
//    - The register file commits on a write_data change, so RegWrite/RegDst lead write_data by one cycle.
//    - RegWrite drops in IDLE; write_data holds its last value.
//  Ignored inputs: alu_done outside EXEC; instr_valid while busy (instr_ready=0, instruction not consumed).
//  Latency: handshake at cycle N -> RegRead N+2 -> alu_start N+3. alu_done at M -> write_data updates at M+2 -> instr_ready at M+3.
//  Back-to-back: next handshake allowed in the first IDLE cycle.
// TESTING
//  1. Reset held 3 cycles, then released.
//     -> All outputs 0 while reset is held; instr_ready=1 after release; busy=0.
//  2. ADD 0x012A4020, alu_done with alu_result=0x00000005 two cycles after alu_start.
//     -> rd=8, RegDst=1, RegRead one cycle, RegWrite 2 cycles, write_data=5 in WB_COMMIT.
//  3. LBU 0x91090004 (opcode 0x24), alu_result=0xDEADBEEF.
//     -> RegDst=0, rt=9, write_data=0xDEADBEEF; instr_ready=1 three cycles after alu_done.
//  4. Opcode 0x3F.
//     -> error pulse in DECODE cycle, no RegRead/RegWrite, back to IDLE; instr_valid held during busy is not consumed.
//  5. ADD with no alu_done (EXEC_TIMEOUT=15).
//     -> error at 15th EXEC cycle, RegWrite never asserted. Repeat with alu_done on timeout cycle -> normal writeback.
//  6. Reset asserted in WB_SETUP.
//     -> next cycle IDLE, RegWrite=0, write_data=0; the following instruction completes normally.

Source files
------------

// File: rtl/control_sequencer.sv
// Multi-cycle control stage ahead of the register file: accepts one instruction,
// sequences the register read, waits on the ALU, then writes back in two phases.
module control_sequencer #(
    parameter int EXEC_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] alu_result,
    input  logic        alu_done,
    output logic        alu_start,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic        RegRead,
    output logic        RegWrite,
    output logic        RegDst,
    output logic [31:0] write_data,
    output logic        busy,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        READ,
        EXEC,
        WB_SETUP,
        WB_COMMIT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  wait_cnt;
    logic [31:0] alu_hold;
    logic        handshake;
    logic        is_rtype;
    logic        is_jr;
    logic        is_itype;
    logic        supported;
    logic        writes_reg;
    logic        timeout;
    logic        unused_shamt;

    assign unused_shamt = ^instr[10:6];

    assign is_rtype   = (opcode == 6'h00) && (funct != 6'h08);
    assign is_jr      = (opcode == 6'h00) && (funct == 6'h08);
    assign is_itype   = (opcode inside {[6'h08:6'h0F], 6'h23, 6'h24, 6'h25});
    assign supported  = is_rtype || is_jr || is_itype;
    assign writes_reg = is_rtype || is_itype;

    // wait_cnt holds the 1-based number of the current EXEC cycle
    assign timeout = (wait_cnt == 8'(EXEC_TIMEOUT));

    assign instr_ready = (state == IDLE) && !reset;
    assign handshake   = instr_valid && instr_ready;
    assign busy        = (state != IDLE);
    assign RegRead     = (state == READ);
    assign alu_start   = (state == EXEC) && (wait_cnt == 8'd1);
    assign RegWrite    = (state == WB_SETUP) || (state == WB_COMMIT);
    assign RegDst      = RegWrite && is_rtype;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= 8'd0;
            write_data <= 32'd0;
            opcode     <= 6'd0;
            rs         <= 5'd0;
            rt         <= 5'd0;
            rd         <= 5'd0;
            funct      <= 6'd0;
        end else begin
            state <= state_nxt;
            if (handshake) begin
                opcode <= instr[31:26];
                rs     <= instr[25:21];
                rt     <= instr[20:16];
                rd     <= instr[15:11];
                funct  <= instr[5:0];
            end
            if (state == READ) begin
                wait_cnt <= 8'd1;
            end else if (state == EXEC) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            // write_data moves one cycle after RegWrite/RegDst so the register
            // file sees a settled address when the data changes
            if (state == WB_SETUP) begin
                write_data <= alu_hold;
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((state == EXEC) && alu_done) begin
            alu_hold <= alu_result;
        end
    end

    always_comb begin
        state_nxt = state;
        error     = 1'b0;
        case (state)
            IDLE: begin
                if (handshake) state_nxt = DECODE;
            end
            DECODE: begin
                if (!supported) begin
                    error     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = READ;
                end
            end
            READ: state_nxt = EXEC;
            EXEC: begin
                // a completion arriving on the timeout cycle still counts
                if (alu_done) begin
                    state_nxt = writes_reg ? WB_SETUP : IDLE;
                end else if (timeout) begin
                    error     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WB_SETUP:  state_nxt = WB_COMMIT;
            WB_COMMIT: state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: a per-transaction timeline model predicts
// every output each cycle; a few hand-computed pins anchor the model.
module tb_control_sequencer;

    localparam int T = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'd0;
    logic        instr_valid = 1'b0;
    logic [31:0] alu_result = 32'd0;
    logic        alu_done = 1'b0;
    logic        instr_ready, alu_start, RegRead, RegWrite, RegDst, busy, error;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  opcode, funct;
    logic [31:0] write_data;

    always #5 clk = ~clk;

    control_sequencer #(.EXEC_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .alu_result(alu_result), .alu_done(alu_done),
        .alu_start(alu_start), .rs(rs), .rt(rt), .rd(rd), .opcode(opcode),
        .funct(funct), .RegRead(RegRead), .RegWrite(RegWrite), .RegDst(RegDst),
        .write_data(write_data), .busy(busy), .error(error)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = -1;

    // Expected outputs for the current cycle
    logic        chk = 1'b0;
    logic        x_ready, x_busy, x_rr, x_as, x_rw, x_rdst, x_err;
    logic [31:0] x_wd, x_ir;

    // Timeline of the transaction in flight, in absolute cycle numbers (-1 = never)
    int p_h = -10, p_rd = -1, p_st = -1, p_done = -1, p_xend = -1;
    int p_err = -1, p_wb1 = -1, p_wb2 = -1, p_end = 0;
    logic        p_rtype = 1'b0;
    logic [31:0] p_res = 32'd0, p_instr = 32'd0, wd_now = 32'd0, ir_now = 32'd0;
    logic        rst_prev = 1'b1;

    typedef struct {
        int          cy;
        int          sel;
        logic [31:0] val;
    } pin_t;
    pin_t pins[$];

    // 0 unsupported, 1 R-type, 2 JR, 3 I-type
    function automatic int cls(input logic [31:0] w);
        logic [5:0] op;
        op = w[31:26];
        if (op == 6'h00) return (w[5:0] == 6'h08) ? 2 : 1;
        if ((op >= 6'h08 && op <= 6'h0F) || op == 6'h23 || op == 6'h24 || op == 6'h25) return 3;
        return 0;
    endfunction

    task automatic clear_plan(input int c);
        p_h = -10; p_rd = -1; p_st = -1; p_done = -1; p_xend = -1;
        p_err = -1; p_wb1 = -1; p_wb2 = -1; p_end = c; p_rtype = 1'b0;
    endtask

    task automatic install(input int h, input logic [31:0] w, input int k, input logic [31:0] res);
        int c;
        c = cls(w);
        clear_plan(h);
        p_h = h; p_instr = w; p_res = res; p_rtype = (c == 1);
        if (c == 0) begin
            p_err = h + 1;
            p_end = h + 2;
        end else begin
            p_rd = h + 2;
            p_st = h + 3;
            if (k >= 1 && k <= T) begin
                p_done = h + 2 + k;
                p_xend = p_done;
                if (c == 1 || c == 3) begin
                    p_wb1 = p_done + 1;
                    p_wb2 = p_done + 2;
                    p_end = p_done + 3;
                end else begin
                    p_end = p_done + 1;
                end
            end else begin
                p_err  = h + 2 + T;
                p_xend = p_err;
                p_end  = p_err + 1;
            end
        end
    endtask

    task automatic eval_cycle(input int c, input logic rst);
        chk = !(rst && !rst_prev);
        if (rst_prev) begin
            clear_plan(c);
            wd_now = 32'd0;
            ir_now = 32'd0;
        end
        if (c == p_h + 1) ir_now = p_instr;
        if (c == p_wb2) wd_now = p_res;
        x_ready  = (c >= p_end) && !rst;
        x_busy   = (c < p_end);
        x_rr     = (c == p_rd);
        x_as     = (c == p_st);
        x_err    = (c == p_err);
        x_rw     = (c == p_wb1) || (c == p_wb2);
        x_rdst   = x_rw && p_rtype;
        x_wd     = wd_now;
        x_ir     = ir_now;
        rst_prev = rst;
    endtask

    task automatic tick(input logic rst, input logic send, input logic [31:0] w, input int k,
                        input logic [31:0] res, input logic junk, input int spur, output logic hs);
        @(posedge clk);
        #1;
        cyc++;
        eval_cycle(cyc, rst);
        reset = rst;
        hs = 1'b0;
        if (!rst && send && x_ready) begin
            instr_valid = 1'b1; instr = w; hs = 1'b1;
        end else if (!rst && junk && x_busy) begin
            instr_valid = 1'b1; instr = $urandom;
        end else begin
            instr_valid = 1'b0; instr = $urandom;
        end
        if (cyc == p_done) begin
            alu_done = 1'b1; alu_result = p_res;
        end else if (!(p_st >= 0 && cyc >= p_st && cyc <= p_xend) &&
                     ($urandom_range(99) < spur)) begin
            alu_done = 1'b1; alu_result = $urandom;
        end else begin
            alu_done = 1'b0; alu_result = $urandom;
        end
        if (hs) install(cyc, w, k, res);
    endtask

    task automatic send_txn(input logic [31:0] w, input int k, input logic [31:0] res,
                            input int gap, input logic junk, input int spur, output int h);
        logic hs;
        int   guard;
        for (int i = 0; i < gap; i++) tick(1'b0, 1'b0, 32'd0, 0, 32'd0, junk, spur, hs);
        hs = 1'b0;
        guard = 0;
        while (!hs && guard < 40) begin
            tick(1'b0, 1'b1, w, k, res, junk, spur, hs);
            guard++;
        end
        h = cyc;
        if (!hs) begin
            n_chk++; n_fail++;
            $display("FAIL handshake: instruction %h not accepted within 40 cycles", w);
        end
    endtask

    task automatic finish_txn(input logic junk, input int spur);
        logic hs;
        int   guard;
        guard = 0;
        while (cyc + 1 < p_end && guard < 100) begin
            tick(1'b0, 1'b0, 32'd0, 0, 32'd0, junk, spur, hs);
            guard++;
        end
    endtask

    task automatic pin(input int cy, input int sel, input logic [31:0] val);
        pin_t p;
        p.cy = cy; p.sel = sel; p.val = val;
        pins.push_back(p);
    endtask

    function automatic logic [31:0] out_val(input int sel);
        case (sel)
            0:  return 32'(instr_ready);
            1:  return 32'(busy);
            2:  return 32'(RegRead);
            3:  return 32'(alu_start);
            4:  return 32'(RegWrite);
            5:  return 32'(RegDst);
            6:  return 32'(error);
            7:  return write_data;
            8:  return 32'(rs);
            9:  return 32'(rt);
            10: return 32'(rd);
            11: return 32'(opcode);
            default: return 32'(funct);
        endcase
    endfunction

    function automatic string sig_name(input int sel);
        case (sel)
            0:  return "instr_ready";
            1:  return "busy";
            2:  return "RegRead";
            3:  return "alu_start";
            4:  return "RegWrite";
            5:  return "RegDst";
            6:  return "error";
            7:  return "write_data";
            8:  return "rs";
            9:  return "rt";
            10: return "rd";
            11: return "opcode";
            default: return "funct";
        endcase
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            cmp("instr_ready", 32'(instr_ready), 32'(x_ready));
            cmp("busy",        32'(busy),        32'(x_busy));
            cmp("RegRead",     32'(RegRead),     32'(x_rr));
            cmp("alu_start",   32'(alu_start),   32'(x_as));
            cmp("RegWrite",    32'(RegWrite),    32'(x_rw));
            cmp("RegDst",      32'(RegDst),      32'(x_rdst));
            cmp("error",       32'(error),       32'(x_err));
            cmp("write_data",  write_data,       x_wd);
            cmp("rs",          32'(rs),          32'(x_ir[25:21]));
            cmp("rt",          32'(rt),          32'(x_ir[20:16]));
            cmp("rd",          32'(rd),          32'(x_ir[15:11]));
            cmp("opcode",      32'(opcode),      32'(x_ir[31:26]));
            cmp("funct",       32'(funct),       32'(x_ir[5:0]));
        end
        for (int i = 0; i < pins.size(); i++)
            if (pins[i].cy == cyc)
                cmp({"pin_", sig_name(pins[i].sel)}, out_val(pins[i].sel), pins[i].val);
    end

    function automatic logic [31:0] rand_instr(input int kind);
        logic [31:0] w;
        int idx;
        w = $urandom;
        case (kind)
            0: begin
                do w[31:26] = 6'($urandom_range(63)); while (cls(w) != 0);
            end
            1: begin
                w[31:26] = 6'h00;
                do w[5:0] = 6'($urandom_range(63)); while (w[5:0] == 6'h08);
            end
            2: begin
                w[31:26] = 6'h00;
                w[5:0] = 6'h08;
            end
            default: begin
                idx = $urandom_range(10);
                w[31:26] = (idx < 8) ? 6'(8 + idx) : 6'(6'h23 + idx - 8);
            end
        endcase
        return w;
    endfunction

    initial begin
        logic hs;
        int   h, r, k;

        // Reset held across three edges, then released
        pin(0, 0, 32'd0); pin(1, 1, 32'd0); pin(1, 7, 32'd0);
        pin(2, 0, 32'd1); pin(2, 1, 32'd0);
        tick(1'b1, 1'b0, 32'd0, 0, 32'd0, 1'b0, 0, hs);
        tick(1'b1, 1'b0, 32'd0, 0, 32'd0, 1'b0, 0, hs);

        // ADD $8,$9,$10 with completion two cycles after alu_start
        send_txn(32'h012A4020, 3, 32'h5, 0, 1'b0, 0, h);
        pin(h + 1, 10, 32'd8); pin(h + 1, 8, 32'd9); pin(h + 1, 9, 32'd10);
        pin(h + 2, 2, 32'd1);  pin(h + 3, 2, 32'd0); pin(h + 3, 3, 32'd1);
        pin(h + 6, 4, 32'd1);  pin(h + 6, 5, 32'd1); pin(h + 6, 7, 32'd0);
        pin(h + 7, 4, 32'd1);  pin(h + 7, 7, 32'd5);
        pin(h + 8, 4, 32'd0);  pin(h + 8, 0, 32'd1); pin(h + 8, 7, 32'd5);
        finish_txn(1'b0, 0);

        // LBU, completion in the alu_start cycle
        send_txn(32'h91090004, 1, 32'hDEADBEEF, 0, 1'b0, 0, h);
        pin(h + 1, 11, 32'h24); pin(h + 1, 8, 32'd8); pin(h + 1, 9, 32'd9);
        pin(h + 4, 5, 32'd0);   pin(h + 4, 4, 32'd1);
        pin(h + 5, 7, 32'hDEADBEEF); pin(h + 5, 0, 32'd0); pin(h + 6, 0, 32'd1);
        finish_txn(1'b0, 0);

        // Unsupported opcode, instr_valid kept high while busy
        send_txn({6'h3F, 26'h0123456}, 2, 32'h0, 0, 1'b1, 0, h);
        pin(h + 1, 6, 32'd1); pin(h + 1, 11, 32'h3F); pin(h + 1, 0, 32'd0);
        pin(h + 2, 0, 32'd1); pin(h + 2, 11, 32'h3F); pin(h + 2, 2, 32'd0); pin(h + 2, 6, 32'd0);
        finish_txn(1'b1, 0);

        // ADD with no completion: timeout
        send_txn(32'h012A4020, 0, 32'h0, 1, 1'b0, 30, h);
        pin(h + 1 + T, 6, 32'd0); pin(h + 2 + T, 6, 32'd1);
        pin(h + 3 + T, 0, 32'd1); pin(h + 3 + T, 4, 32'd0);
        finish_txn(1'b0, 30);

        // ADD with completion on the timeout cycle
        send_txn(32'h014B6020, T, 32'hA5A5_0F0F, 0, 1'b0, 0, h);
        pin(h + 2 + T, 6, 32'd0); pin(h + 3 + T, 4, 32'd1); pin(h + 4 + T, 7, 32'hA5A5_0F0F);
        finish_txn(1'b0, 0);

        // Reset during WB_SETUP, then a normal instruction straight after
        send_txn(32'h014B6020, 2, 32'h0000_0077, 0, 1'b0, 0, h);
        while (cyc + 1 < p_wb1) tick(1'b0, 1'b0, 32'd0, 0, 32'd0, 1'b0, 0, hs);
        r = p_wb1;
        tick(1'b1, 1'b0, 32'd0, 0, 32'd0, 1'b0, 0, hs);
        pin(r + 1, 4, 32'd0); pin(r + 1, 7, 32'd0); pin(r + 1, 0, 32'd1); pin(r + 1, 1, 32'd0);
        send_txn(32'h012A4020, 2, 32'h0000_1234, 0, 1'b0, 0, h);
        pin(h + 6, 7, 32'h0000_1234);
        finish_txn(1'b0, 0);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            logic [31:0] w;
            logic        junk;
            r = $urandom_range(9);
            if (r == 0)      k = 0;
            else if (r == 1) k = T;
            else if (r == 2) k = 1;
            else             k = $urandom_range(2, 8);
            w = rand_instr($urandom_range(3));
            junk = 1'($urandom_range(1));
            send_txn(w, k, $urandom, $urandom_range(2), junk, 20, h);
            finish_txn(junk, 20);
        end

        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'd0, 0, 32'd0, 1'b0, 20, hs);
        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
